// File: rtl/psum_writeback_pkg.sv
// Shared PE-array definitions: writeback FSM state encoding and the
// per-column ReLU decision used when partial sums are written to SRAM.
package psum_writeback_pkg;

    // Writeback controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } wb_state_e;

    // A column is forced to zero only when ReLU is enabled and the column is negative.
    function automatic logic relu_clear_col(input logic relu_en, input logic sign_bit);
        return relu_en & sign_bit;
    endfunction

endpackage

// File: rtl/psum_writeback_fifo.sv
// psum_fifo: small synchronous FIFO with registered storage and pointers.
// The head entry is readable combinationally; a push while full is dropped
// even if a pop happens in the same cycle (no pass-through).
module psum_fifo #(
    parameter int width = 16,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int            PW       = $clog2(depth);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1'b1);
    localparam logic [PW:0]   CNT_ZERO = (PW + 1)'(1'b0);
    localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(depth);

    logic [width-1:0] mem_q [depth];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == CNT_ZERO);
    assign rdata     = mem_q[rd_ptr_q];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage, pointers and occupancy; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/psum_writeback.sv
// psum_writeback: accepts accumulated psum vectors from the SFU through a
// small FIFO and writes them to consecutive output-SRAM addresses starting
// at a job base address, with optional per-column ReLU. All SRAM-side
// outputs, busy and done are registered.
module psum_writeback
    import psum_writeback_pkg::*;
#(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int depth   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addr_bw-1:0]     base_addr,
    input  logic [addr_bw-1:0]     num_vec,
    input  logic                   relu_en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [col*psum_bw-1:0] psum_in,
    output logic                   mem_cen,
    output logic                   mem_wen,
    output logic [addr_bw-1:0]     mem_addr,
    output logic [col*psum_bw-1:0] mem_d,
    output logic                   busy,
    output logic                   done
);

    localparam int                 VEC_W  = col * psum_bw;
    localparam logic [addr_bw-1:0] A_ONE  = addr_bw'(1'b1);
    localparam logic [addr_bw-1:0] A_ZERO = addr_bw'(1'b0);

    wb_state_e          state_q;
    logic [addr_bw-1:0] base_q;
    logic [addr_bw-1:0] num_q;
    logic               relu_q;
    logic [addr_bw-1:0] acc_cnt_q;
    logic [addr_bw-1:0] wr_cnt_q;
    logic               mem_cen_q;
    logic               mem_wen_q;
    logic [addr_bw-1:0] mem_addr_q;
    logic [VEC_W-1:0]   mem_d_q;
    logic               busy_q;
    logic               done_q;

    logic               in_ready_s;
    logic               push_s;
    logic               pop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [VEC_W-1:0]   head_s;
    logic [VEC_W-1:0]   relu_data_s;

    // Input buffer between the SFU handshake and the SRAM write port
    psum_fifo #(
        .width (VEC_W),
        .depth (depth)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (psum_in),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Ready depends only on registered state so there is no in_valid -> in_ready path.
    always_comb begin
        in_ready_s = 1'b0;
        if ((state_q == ST_RUN) && !fifo_full_s && (acc_cnt_q < num_q)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    // Pop the head whenever a job is running and there is buffered data still owed.
    always_comb begin
        pop_s = 1'b0;
        if ((state_q == ST_RUN) && !fifo_empty_s && (wr_cnt_q < num_q)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign push_s = in_valid & in_ready_s;

    // Apply ReLU column by column to the FIFO head before it is registered onto the SRAM bus.
    always_comb begin
        relu_data_s = head_s;
        for (int j = 0; j < col; j++) begin
            if (relu_clear_col(relu_q, head_s[j*psum_bw + psum_bw - 1])) begin
                relu_data_s[j*psum_bw +: psum_bw] = '0;
            end else begin
                relu_data_s[j*psum_bw +: psum_bw] = head_s[j*psum_bw +: psum_bw];
            end
        end
    end

    // Controller FSM with job parameters, counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            base_q     <= A_ZERO;
            num_q      <= A_ZERO;
            relu_q     <= 1'b0;
            acc_cnt_q  <= A_ZERO;
            wr_cnt_q   <= A_ZERO;
            mem_cen_q  <= 1'b1;
            mem_wen_q  <= 1'b1;
            mem_addr_q <= A_ZERO;
            mem_d_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Idle SRAM cycle unless a pop below issues a write; address/data hold.
            mem_cen_q <= 1'b1;
            mem_wen_q <= 1'b1;
            done_q    <= 1'b0;

            if (push_s) begin
                acc_cnt_q <= acc_cnt_q + A_ONE;
            end

            if (pop_s) begin
                mem_cen_q  <= 1'b0;
                mem_wen_q  <= 1'b0;
                mem_addr_q <= base_q + wr_cnt_q;
                mem_d_q    <= relu_data_s;
                wr_cnt_q   <= wr_cnt_q + A_ONE;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        num_q     <= num_vec;
                        relu_q    <= relu_en;
                        acc_cnt_q <= A_ZERO;
                        wr_cnt_q  <= A_ZERO;
                        busy_q    <= 1'b1;
                        if (num_vec == A_ZERO) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    busy_q <= 1'b1;
                    // The final write was issued last edge and is on the port now.
                    if (wr_cnt_q == num_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_s;
    assign mem_cen  = mem_cen_q;
    assign mem_wen  = mem_wen_q;
    assign mem_addr = mem_addr_q;
    assign mem_d    = mem_d_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_psum_writeback.sv
// Directed testbench for psum_writeback (default parameters) plus a
// standalone psum_fifo instance whose pops are held off to exercise full.
module tb_psum_writeback;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [10:0]  base_addr;
    logic [10:0]  num_vec;
    logic         relu_en;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] psum_in;
    logic         mem_cen;
    logic         mem_wen;
    logic [10:0]  mem_addr;
    logic [127:0] mem_d;
    logic         busy;
    logic         done;

    logic         f_rst;
    logic         f_push;
    logic         f_pop;
    logic [15:0]  f_wdata;
    logic [15:0]  f_rdata;
    logic         f_full;
    logic         f_empty;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int done_n = 0;
    int rdy_n  = 0;

    logic [10:0]  wr_addr [$];
    logic [127:0] wr_data [$];
    int           wr_cyc  [$];
    logic [127:0] stim    [8];

    psum_writeback dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_vec   (num_vec),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .psum_in   (psum_in),
        .mem_cen   (mem_cen),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_d     (mem_d),
        .busy      (busy),
        .done      (done)
    );

    psum_fifo #(.width(16), .depth(4)) u_fifo_chk (
        .clk   (clk),
        .reset (f_rst),
        .push  (f_push),
        .pop   (f_pop),
        .wdata (f_wdata),
        .rdata (f_rdata),
        .full  (f_full),
        .empty (f_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record every SRAM write, done pulse and ready cycle in the middle of the cycle.
    always @(negedge clk) begin
        if (mem_cen === 1'b0) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_d);
            wr_cyc.push_back(cyc);
            chk("wen_with_cen", {127'd0, mem_wen}, 128'd0);
        end
        if (done === 1'b1) done_n++;
        if (in_ready === 1'b1) rdy_n++;
    end

    function automatic logic [127:0] gen_vec(input int k);
        logic [127:0] v;
        for (int j = 0; j < 8; j++) begin
            v[j*16 +: 16] = 16'(k * 256 + j);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [10:0] b, input logic [10:0] n, input logic r);
        base_addr = b;
        num_vec   = n;
        relu_en   = r;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Present stim[0..n-1] with in_valid held high; each transfer happens at the next edge.
    task automatic feed(input int n, output int first_cyc);
        int w;
        first_cyc = -1;
        for (int i = 0; i < n; i++) begin
            psum_in  = stim[i];
            in_valid = 1'b1;
            w = 0;
            while (!in_ready && w < 40 && !reset) begin
                tick();
                start = 1'b0;
                w++;
            end
            if (reset) break;
            if (w >= 40) begin
                chk("feed_timeout", 128'd1, 128'd0);
                break;
            end
            tick();
            start = 1'b0;
            if (i == 0) first_cyc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int w;
        w = 0;
        while (!done && w < 60) begin
            tick();
            w++;
        end
        chk({tag, "_done_seen"}, {127'd0, done}, 128'd1);
        tick();
        chk({tag, "_done_pulse"}, {127'd0, done}, 128'd0);
        chk({tag, "_busy_idle"}, {127'd0, busy}, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx0;
        int d0;
        int r0;
        int fc;
        int w;

        reset = 1'b1; start = 1'b0; base_addr = 11'h000; num_vec = 11'h000;
        relu_en = 1'b0; in_valid = 1'b0; psum_in = 128'd0;
        f_rst = 1'b1; f_push = 1'b0; f_pop = 1'b0; f_wdata = 16'h0000;
        tick(); tick();

        // Reset values
        chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
        chk("rst_mem_cen",  {127'd0, mem_cen},  128'd1);
        chk("rst_mem_wen",  {127'd0, mem_wen},  128'd1);
        chk("rst_mem_addr", {117'd0, mem_addr}, 128'd0);
        chk("rst_mem_d",    mem_d,              128'd0);
        chk("rst_busy",     {127'd0, busy},     128'd0);
        chk("rst_done",     {127'd0, done},     128'd0);
        reset = 1'b0;
        tick();

        // A: three vectors to 0x010.., relu off, negative columns pass unchanged
        idx0 = wr_addr.size(); d0 = done_n;
        for (int i = 0; i < 3; i++) stim[i] = gen_vec(8'h80 + i);
        do_start(11'h010, 11'd3, 1'b0);
        chk("A_busy_run", {127'd0, busy}, 128'd1);
        feed(3, fc);
        wait_done("A");
        chk("A_nwrites", 128'(wr_addr.size() - idx0), 128'd3);
        chk("A_addr0", {117'd0, wr_addr[idx0]},     {117'd0, 11'h010});
        chk("A_addr1", {117'd0, wr_addr[idx0 + 1]}, {117'd0, 11'h011});
        chk("A_addr2", {117'd0, wr_addr[idx0 + 2]}, {117'd0, 11'h012});
        chk("A_data0", wr_data[idx0],     128'h8007_8006_8005_8004_8003_8002_8001_8000);
        chk("A_data1", wr_data[idx0 + 1], 128'h8107_8106_8105_8104_8103_8102_8101_8100);
        chk("A_data2", wr_data[idx0 + 2], 128'h8207_8206_8205_8204_8203_8202_8201_8200);
        chk("A_latency",  128'(wr_cyc[idx0] - fc), 128'd1);
        chk("A_back2back1", 128'(wr_cyc[idx0 + 1] - wr_cyc[idx0]), 128'd1);
        chk("A_back2back2", 128'(wr_cyc[idx0 + 2] - wr_cyc[idx0 + 1]), 128'd1);
        chk("A_done_count", 128'(done_n - d0), 128'd1);

        // B: ReLU clears negative columns only
        idx0 = wr_addr.size();
        stim[0] = 128'h8000_0000_0000_0000_0000_7FFF_0005_FFF0;
        do_start(11'h100, 11'd1, 1'b1);
        feed(1, fc);
        wait_done("B");
        chk("B_nwrites", 128'(wr_addr.size() - idx0), 128'd1);
        chk("B_addr", {117'd0, wr_addr[idx0]}, {117'd0, 11'h100});
        chk("B_col0", {112'd0, wr_data[idx0][15:0]},  128'h0000);
        chk("B_col1", {112'd0, wr_data[idx0][31:16]}, 128'h0005);
        chk("B_data", wr_data[idx0], 128'h0000_0000_0000_0000_0000_7FFF_0005_0000);

        // C: empty job goes straight to DONE and never accepts
        idx0 = wr_addr.size(); d0 = done_n; r0 = rdy_n;
        in_valid = 1'b1;
        psum_in  = 128'h1234;
        do_start(11'h020, 11'd0, 1'b0);
        chk("C_done_next", {127'd0, done}, 128'd1);
        chk("C_busy_done", {127'd0, busy}, 128'd1);
        tick();
        chk("C_done_once", {127'd0, done}, 128'd0);
        chk("C_busy_after", {127'd0, busy}, 128'd0);
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk("C_nwrites", 128'(wr_addr.size() - idx0), 128'd0);
        chk("C_never_ready", 128'(rdy_n - r0), 128'd0);
        chk("C_done_count", 128'(done_n - d0), 128'd1);

        // D: address wrap past 0x7FF; a second start while running is ignored
        idx0 = wr_addr.size(); d0 = done_n;
        for (int i = 0; i < 4; i++) stim[i] = gen_vec(8'h90 + i);
        do_start(11'h7FE, 11'd4, 1'b0);
        start = 1'b1; base_addr = 11'h055; num_vec = 11'd1; relu_en = 1'b1;
        feed(4, fc);
        wait_done("D");
        chk("D_nwrites", 128'(wr_addr.size() - idx0), 128'd4);
        chk("D_addr0", {117'd0, wr_addr[idx0]},     {117'd0, 11'h7FE});
        chk("D_addr1", {117'd0, wr_addr[idx0 + 1]}, {117'd0, 11'h7FF});
        chk("D_addr2", {117'd0, wr_addr[idx0 + 2]}, {117'd0, 11'h000});
        chk("D_addr3", {117'd0, wr_addr[idx0 + 3]}, {117'd0, 11'h001});
        chk("D_data3_norelu", wr_data[idx0 + 3], 128'h9307_9306_9305_9304_9303_9302_9301_9300);
        chk("D_done_count", 128'(done_n - d0), 128'd1);

        // E: eight-vector job, order preserved and accept stops at the job length
        idx0 = wr_addr.size();
        for (int i = 0; i < 8; i++) stim[i] = gen_vec(8'h10 + i);
        do_start(11'h400, 11'd8, 1'b0);
        feed(8, fc);
        chk("E_ready_low_at_limit", {127'd0, in_ready}, 128'd0);
        chk("E_busy_draining", {127'd0, busy}, 128'd1);
        wait_done("E");
        chk("E_nwrites", 128'(wr_addr.size() - idx0), 128'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("E_addr%0d", i), {117'd0, wr_addr[idx0 + i]}, {117'd0, 11'h400 + 11'(i)});
            chk($sformatf("E_data%0d", i), wr_data[idx0 + i], gen_vec(8'h10 + i));
        end

        // F: reset after two of five writes abandons the job
        idx0 = wr_addr.size();
        for (int i = 0; i < 5; i++) stim[i] = gen_vec(8'h30 + i);
        do_start(11'h300, 11'd5, 1'b0);
        fork
            begin
                feed(5, fc);
            end
            begin
                w = 0;
                while (w < 40 && !(mem_cen === 1'b0 && mem_addr === 11'h301)) begin
                    tick();
                    w++;
                end
                chk("F_second_write_seen", 128'(w < 40), 128'd1);
                @(negedge clk);
                #1 reset = 1'b1;
                #1;
                chk("F_rst_mem_cen",  {127'd0, mem_cen},  128'd1);
                chk("F_rst_mem_wen",  {127'd0, mem_wen},  128'd1);
                chk("F_rst_mem_addr", {117'd0, mem_addr}, 128'd0);
                chk("F_rst_mem_d",    mem_d,              128'd0);
                chk("F_rst_busy",     {127'd0, busy},     128'd0);
                chk("F_rst_ready",    {127'd0, in_ready}, 128'd0);
                chk("F_rst_done",     {127'd0, done},     128'd0);
            end
        join
        in_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("F_writes_before_reset", 128'(wr_addr.size() - idx0), 128'd2);

        idx0 = wr_addr.size();
        stim[0] = gen_vec(8'h40);
        stim[1] = gen_vec(8'h41);
        do_start(11'h200, 11'd2, 1'b0);
        feed(2, fc);
        wait_done("F2");
        chk("F2_nwrites", 128'(wr_addr.size() - idx0), 128'd2);
        chk("F2_addr0", {117'd0, wr_addr[idx0]},     {117'd0, 11'h200});
        chk("F2_addr1", {117'd0, wr_addr[idx0 + 1]}, {117'd0, 11'h201});
        chk("F2_data0", wr_data[idx0],     128'h4007_4006_4005_4004_4003_4002_4001_4000);
        chk("F2_data1", wr_data[idx0 + 1], 128'h4107_4106_4105_4104_4103_4102_4101_4100);

        // G: standalone buffer with pops held off until it fills
        f_rst = 1'b0;
        tick();
        chk("G_rst_empty", {127'd0, f_empty}, 128'd1);
        chk("G_rst_full",  {127'd0, f_full},  128'd0);
        for (int i = 0; i < 4; i++) begin
            f_wdata = 16'h00A0 + 16'(i);
            f_push  = 1'b1;
            tick();
        end
        chk("G_full_after4", {127'd0, f_full}, 128'd1);
        chk("G_head_a0", {112'd0, f_rdata}, 128'h00A0);
        f_wdata = 16'h00A4;
        tick();
        chk("G_full_hold", {127'd0, f_full}, 128'd1);
        f_wdata = 16'h00A5;
        f_pop   = 1'b1;
        tick();
        f_push = 1'b0;
        chk("G_full_pushpop", {127'd0, f_full}, 128'd0);
        chk("G_head_a1", {112'd0, f_rdata}, 128'h00A1);
        tick();
        chk("G_head_a2", {112'd0, f_rdata}, 128'h00A2);
        tick();
        chk("G_head_a3", {112'd0, f_rdata}, 128'h00A3);
        tick();
        f_pop = 1'b0;
        chk("G_empty_drained", {127'd0, f_empty}, 128'd1);
        f_wdata = 16'h00B0;
        f_push  = 1'b1;
        tick();
        chk("G_head_b0", {112'd0, f_rdata}, 128'h00B0);
        f_wdata = 16'h00B1;
        f_pop   = 1'b1;
        tick();
        f_push = 1'b0;
        chk("G_head_b1", {112'd0, f_rdata}, 128'h00B1);
        chk("G_occ_kept", {127'd0, f_empty}, 128'd0);
        tick();
        f_pop = 1'b0;
        chk("G_empty_end", {127'd0, f_empty}, 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/psum_writeback.md
PSUM_WRITEBACK -- requirements
Module: psum_writeback

Interface
REQ-001 Parameter psum_bw, default 16: width of one signed per-column partial sum.
REQ-002 Parameter col, default 8: number of columns per psum vector.
REQ-003 Parameter addr_bw, default 11: output SRAM address width.
REQ-004 Parameter depth, default 4 (power of two, >=2): input buffer entries.
REQ-005 Port clk  input  1: single clock; all logic on rising edge.
REQ-006 Port reset  input  1: asynchronous, active-high reset.
REQ-007 Port start  input  1: one-cycle pulse that begins a writeback job.
REQ-008 Port base_addr  input  addr_bw: first SRAM address of the job, sampled on start.
REQ-009 Port num_vec  input  addr_bw: vectors in the job, sampled on start.
REQ-010 Port relu_en  input  1: zero negative columns at write, sampled on start.
REQ-011 Port in_valid  input  1: psum_in holds an accumulated vector from the SFU.
REQ-012 Port in_ready  output  1: block accepts psum_in this cycle.
REQ-013 Port psum_in  input  col*psum_bw: column j at bits [(j+1)*psum_bw-1 : j*psum_bw].
REQ-014 Port mem_cen  output  1: SRAM chip enable, active low.
REQ-015 Port mem_wen  output  1: SRAM write enable, active low.
REQ-016 Port mem_addr  output  addr_bw: SRAM address.
REQ-017 Port mem_d  output  col*psum_bw: SRAM write data, same column packing as psum_in.
REQ-018 Port busy  output  1: high in RUN and DONE.
REQ-019 Port done  output  1: one-cycle pulse when the last vector has been written.

Function
REQ-020 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-021 IDLE + start: latch base_addr, num_vec, relu_en; clear accept and write counters; go RUN, or DONE if num_vec==0.
REQ-022 start outside IDLE is ignored; latched job parameters do not change.
REQ-023 Transfer occurs when in_valid && in_ready; the vector is pushed into the FIFO on that edge.
REQ-024 in_ready = (state==RUN) && FIFO not full && accept_count < num_vec; purely registered-state based, no combinational path from in_valid.
REQ-025 In RUN, when the FIFO is non-empty, the head is popped and a write issued the following cycle: mem_cen=0, mem_wen=0, mem_addr=base_addr+write_count, mem_d=head (after ReLU).
REQ-026 Latency: a vector accepted into an empty FIFO at edge N appears on the SRAM port in the cycle after edge N+1; sustained throughput one vector per cycle.
REQ-027 Push and pop in the same cycle are both honoured; occupancy unchanged.
REQ-028 When full, in_ready is low; no pass-through on a simultaneous pop.
REQ-029 Address arithmetic modulo 2^addr_bw; base_addr+write_count wraps silently past the top.
REQ-030 relu_en=1: a column whose MSB is 1 is written as zero; other columns unchanged; relu_en=0: data written unmodified.
REQ-031 Cycles with no write: mem_cen=1, mem_wen=1, mem_addr and mem_d hold their last values.
REQ-032 After the write with write_count==num_vec-1 completes, go DONE; DONE asserts done for exactly one cycle, then returns to IDLE.
REQ-033 in_valid in IDLE or DONE is not accepted (in_ready low); data is not stored.

Reset
REQ-034 Reset clears state to IDLE, FIFO pointers and occupancy to empty, counters to 0, latched parameters to 0.
REQ-035 Reset values: in_ready=0, mem_cen=1, mem_wen=1, mem_addr=0, mem_d=0, busy=0, done=0.
REQ-036 Reset mid-job abandons the job immediately; buffered vectors are discarded and no further SRAM write is issued.

Structure
REQ-037 FSM state encoding and the ReLU-per-column function belong in the shared PE-array package.
REQ-038 The buffer is one sub-module, psum_fifo (parameters width, depth; push/pop/full/empty), reusable elsewhere in the array.

Verification
REQ-039 base=0x010, num_vec=3, relu_en=0, in_valid constant with vectors V0..V2 -> writes to 0x010,0x011,0x012 in consecutive cycles, data V0..V2, one done pulse.
REQ-040 relu_en=1, column 0 = 0xFFF0, column 1 = 0x0005 -> mem_d column 0 = 0x0000, column 1 = 0x0005.
REQ-041 start with num_vec=0 -> DONE the next cycle, done pulse, mem_cen stays 1, in_ready never high.
REQ-042 base=0x7FE (addr_bw=11), num_vec=4 -> addresses 0x7FE,0x7FF,0x000,0x001.
REQ-043 num_vec=8, depth=4, stall-free input with pops forced to stall via a bench-held FIFO model -> in_ready drops after 4 accepts, no vector lost or duplicated, order preserved.
REQ-044 Reset asserted after 2 of 5 writes -> outputs at reset values within the same cycle, no further writes, next start runs a clean job.
